// File: rtl/forward_unit_nport.sv
// -----------------------------------------------------------------------------
// forward_unit_nport
//
// Operand-forwarding and load-use hazard unit for the pipelined RV32 core.
// It sits between the register-file read and the ALU inputs.
//
// For each read port it picks the freshest copy of the source register from
// one of these places:
//   - the EX result,
//   - the current writeback,
//   - a DEPTH-deep writeback delay line, which covers the register-file
//     write latency,
//   - the register file itself.
// It also holds the front end for LOAD_LAT cycles when an operand depends
// on a load that is still in EX.
//
// Parameters
//   WIDTH     operand/data width
//   NUM_RD    number of read operand ports
//   DEPTH     writeback delay-line entries (>=1)
//   LOAD_LAT  stall cycles per load-use hazard (>=1, <=16)
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   flush       in   synchronous clear of the delay line and the stall FSM
//   rs_addr     in   NUM_RD*5 source register numbers, port i = [5i+4:5i]
//   rs_used     in   NUM_RD per-port "operand consumed this cycle"
//   rf_rdata    in   NUM_RD*WIDTH register-file read data
//   ex_valid    in   EX holds a valid register-writing instruction
//   ex_rd       in   EX destination register
//   ex_is_load  in   EX instruction is a load (result not yet available)
//   ex_result   in   EX ALU result
//   wb_valid    in   writeback commits this cycle
//   wb_rd       in   writeback destination register
//   wb_data     in   writeback data
//   src_data    out  NUM_RD*WIDTH forwarded operand per port
//   fwd_sel     out  NUM_RD*2 per-port source: 00 rf, 01 ex, 10 wb, 11 delay line
//   stall       out  hold IF/DE and insert a bubble in EX
//   fwd_count   out  saturating count of non-stalled cycles that forwarded
// -----------------------------------------------------------------------------
module forward_unit_nport #(
  parameter int WIDTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int DEPTH    = 2,
  parameter int LOAD_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic [NUM_RD*5-1:0]       rs_addr,
  input  logic [NUM_RD-1:0]         rs_used,
  input  logic [NUM_RD*WIDTH-1:0]   rf_rdata,
  input  logic                      ex_valid,
  input  logic [4:0]                ex_rd,
  input  logic                      ex_is_load,
  input  logic [WIDTH-1:0]          ex_result,
  input  logic                      wb_valid,
  input  logic [4:0]                wb_rd,
  input  logic [WIDTH-1:0]          wb_data,
  output logic [NUM_RD*WIDTH-1:0]   src_data,
  output logic [NUM_RD*2-1:0]       fwd_sel,
  output logic                      stall,
  output logic [15:0]               fwd_count
);

  localparam logic [1:0] SEL_RF = 2'b00;
  localparam logic [1:0] SEL_EX = 2'b01;
  localparam logic [1:0] SEL_WB = 2'b10;
  localparam logic [1:0] SEL_DL = 2'b11;

  // A single-cycle load latency is fully covered by the combinational stall,
  // so the FSM only leaves IDLE when more than one stall cycle is needed.
  localparam bit         MULTI_CYCLE = (LOAD_LAT > 1);
  localparam logic [3:0] STALL_INIT  = 4'(LOAD_LAT - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Writeback delay line: entry 0 is the youngest
  // ---------------------------------------------------------------------------
  logic [DEPTH-1:0]            dl_valid_q, dl_valid_d;
  logic [DEPTH-1:0][4:0]       dl_rd_q,    dl_rd_d;
  logic [DEPTH-1:0][WIDTH-1:0] dl_data_q,  dl_data_d;

  // x0 writes are dropped on entry, so lookups never need to special-case them.
  assign dl_valid_d[0] = !flush && wb_valid && (wb_rd != 5'd0);
  assign dl_rd_d[0]    = wb_rd;
  assign dl_data_d[0]  = wb_data;

  generate
    for (genvar gi = 1; gi < DEPTH; gi++) begin : g_dl_shift
      assign dl_valid_d[gi] = !flush && dl_valid_q[gi-1];
      assign dl_rd_d[gi]    = dl_rd_q[gi-1];
      assign dl_data_d[gi]  = dl_data_q[gi-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_valid_q <= '0;
      dl_rd_q    <= '0;
      dl_data_q  <= '0;
    end else begin
      dl_valid_q <= dl_valid_d;
      dl_rd_q    <= dl_rd_d;
      dl_data_q  <= dl_data_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-port operand select and load-use match
  // ---------------------------------------------------------------------------
  logic [NUM_RD-1:0] port_load_hit;

  generate
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_port
      logic [4:0]       rs;
      logic             dl_hit;
      logic [WIDTH-1:0] dl_val;
      logic [WIDTH-1:0] data;
      logic [1:0]       sel;

      assign rs = rs_addr[5*gi +: 5];

      // The scan runs oldest to youngest, so the youngest match overwrites
      // any older one.
      always_comb begin
        dl_hit = 1'b0;
        dl_val = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
          if (dl_valid_q[k] && (dl_rd_q[k] == rs)) begin
            dl_hit = 1'b1;
            dl_val = dl_data_q[k];
          end
        end
      end

      // A load in EX has no result yet. It is skipped here, so older
      // producers still supply the operand while the stall is applied.
      always_comb begin
        data = rf_rdata[gi*WIDTH +: WIDTH];
        sel  = SEL_RF;
        if (rs == 5'd0) begin
          data = '0;
          sel  = SEL_RF;
        end else if (ex_valid && !ex_is_load && (ex_rd == rs)) begin
          data = ex_result;
          sel  = SEL_EX;
        end else if (wb_valid && (wb_rd == rs)) begin
          data = wb_data;
          sel  = SEL_WB;
        end else if (dl_hit) begin
          data = dl_val;
          sel  = SEL_DL;
        end
      end

      assign src_data[gi*WIDTH +: WIDTH] = data;
      assign fwd_sel[2*gi +: 2]          = sel;
      assign port_load_hit[gi]           = rs_used[gi] && (rs == ex_rd);
    end
  endgenerate

  logic hazard;
  assign hazard = ex_valid && ex_is_load && (ex_rd != 5'd0) && (|port_load_hit);

  // ---------------------------------------------------------------------------
  // Stall FSM: state register, next-state logic, and output logic
  // ---------------------------------------------------------------------------
  state_t     state_q, state_d;
  logic [3:0] cnt_q,   cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          // The first stall cycle is issued from IDLE, so STALL covers
          // the remaining LOAD_LAT-1 cycles.
          if (hazard && MULTI_CYCLE) begin
            state_d = STALL;
            cnt_d   = STALL_INIT;
          end
        end
        STALL: begin
          if (cnt_q == 4'd1) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  always_comb begin
    stall = !flush && ((state_q == STALL) || ((state_q == IDLE) && hazard));
  end

  // ---------------------------------------------------------------------------
  // Forwarding activity counter (saturating)
  // ---------------------------------------------------------------------------
  logic        any_fwd;
  logic [15:0] fwd_count_q, fwd_count_d;

  assign any_fwd = |fwd_sel;

  always_comb begin
    fwd_count_d = fwd_count_q;
    if (any_fwd && !stall && (fwd_count_q != 16'hFFFF)) begin
      fwd_count_d = fwd_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_count_q <= 16'd0;
    end else begin
      fwd_count_q <= fwd_count_d;
    end
  end

  assign fwd_count = fwd_count_q;

endmodule
